// File: rtl/shift_sequencer.sv
// Multi-cycle controller for a 4-mode shift register: loads the operand, then steps it one
// position per clock to perform SLL, SRL or SRA by shamt, and returns the final contents.
module shift_sequencer #(
  parameter int N   = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [N-1:0]   operand,
  input  logic [SHW-1:0] shamt,
  output logic           ready,
  output logic           done,
  output logic [N-1:0]   result,
  output logic [N-1:0]   sr_i,
  output logic [1:0]     sr_s,
  output logic           sr_bit,
  input  logic [N-1:0]   sr_q
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  localparam logic [SHW-1:0] CNT_ZERO = '0;
  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  logic [1:0]     state_q, state_d;
  logic [SHW-1:0] count_q, count_d;
  logic [1:0]     op_q, op_d;
  logic [N-1:0]   operand_q, operand_d;
  logic [N-1:0]   result_q, result_d;

  // Next-state and capture logic; requests are only taken in IDLE, so start while busy is dropped.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    operand_d = operand_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          operand_d = operand;
          op_d      = op;
          count_d   = shamt;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (count_q == CNT_ZERO || op_q == OP_RSV) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        result_d = sr_q;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      op_q      <= OP_SLL;
      operand_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      result_q  <= result_d;
    end
  end

  // Shift-register control decodes straight from state and the captured op.
  always_comb begin
    sr_s   = SEL_HOLD;
    sr_bit = 1'b0;
    case (state_q)
      ST_LOAD: sr_s = SEL_LOAD;
      ST_SHIFT: begin
        case (op_q)
          OP_SLL: sr_s = SEL_LEFT;
          OP_SRL: sr_s = SEL_RIGHT;
          OP_SRA: begin
            // The sign bit re-enters at the top on every right step.
            sr_s   = SEL_RIGHT;
            sr_bit = sr_q[N-1];
          end
          default: sr_s = SEL_HOLD;
        endcase
      end
      default: begin
        sr_s   = SEL_HOLD;
        sr_bit = 1'b0;
      end
    endcase
  end

  assign ready  = (state_q == ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign sr_i   = operand_q;
  // Result is live from the register during DONE and held from the latched copy afterwards.
  assign result = done ? sr_q : result_q;

endmodule
